// File: rtl/phi_pkg.sv
// ============================================================================
// Module  : phi_pkg
// Purpose : Shared types and defaults for the divider arbitration slice.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package phi_pkg;

  localparam int DIV_LATENCY_DEFAULT = 65;
  localparam int DIV_WIDTH           = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================================
// Module  : rr_picker
// Purpose : Combinational round-robin pick, searching from last_grant+1 with wrap.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_in,
  input  logic [IDX_W-1:0]   last_grant_in,
  output logic [NUM_REQ-1:0] grant_out,
  output logic [IDX_W-1:0]   grant_idx_out,
  output logic               any_out
);

  always_comb begin
    int         c;
    logic       found;
    logic [IDX_W-1:0] pos;
    grant_out     = '0;
    grant_idx_out = '0;
    found         = 1'b0;
    c             = 0;
    pos           = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      c = int'(last_grant_in) + off;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      pos = IDX_W'(c);
      if (!found && req_in[pos]) begin
        found          = 1'b1;
        grant_out[pos] = 1'b1;
        grant_idx_out  = pos;
      end
    end
    any_out = found;
  end

endmodule

`default_nettype wire

// File: rtl/div_arbiter.sv
// ============================================================================
// Module  : div_arbiter
// Purpose : Round-robin share of one fixed-latency divider among NUM_REQ users.
//           Optional macro DIV_ARB_ZERO_GUARD_EN short-circuits divisor==0.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module div_arbiter
  import phi_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = DIV_WIDTH,
  parameter int DIV_LATENCY = DIV_LATENCY_DEFAULT
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [NUM_REQ-1:0]       req_valid_in,
  output logic [NUM_REQ-1:0]       req_ready_out,
  input  logic [NUM_REQ*WIDTH-1:0] req_dividend_in,
  input  logic [NUM_REQ*WIDTH-1:0] req_divisor_in,
  output logic [NUM_REQ-1:0]       resp_valid_out,
  output logic [WIDTH-1:0]         resp_quotient_out,
  output logic [WIDTH-1:0]         resp_remainder_out,
  output logic [WIDTH-1:0]         div_dividend_out,
  output logic [WIDTH-1:0]         div_divisor_out,
  output logic                     div_valid_out,
  input  logic [WIDTH-1:0]         div_quotient_in,
  input  logic [WIDTH-1:0]         div_remainder_in,
  output logic                     busy_out
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(DIV_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LATENCY - 1);

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_last_grant;
  logic [IDX_W-1:0] r_owner;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_div_dividend;
  logic [WIDTH-1:0] r_div_divisor;
  logic [WIDTH-1:0] r_resp_q;
  logic [WIDTH-1:0] r_resp_r;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic [WIDTH-1:0]   w_sel_dividend;
  logic [WIDTH-1:0]   w_sel_divisor;
  logic               w_zero_div;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .req_in        (req_valid_in),
    .last_grant_in (r_last_grant),
    .grant_out     (w_grant),
    .grant_idx_out (w_idx),
    .any_out       (w_any)
  );

  assign w_sel_dividend = req_dividend_in[w_idx*WIDTH +: WIDTH];
  assign w_sel_divisor  = req_divisor_in[w_idx*WIDTH +: WIDTH];

`ifdef DIV_ARB_ZERO_GUARD_EN
  assign w_zero_div = (w_sel_divisor == '0);
`else
  assign w_zero_div = 1'b0;
`endif

  // Ready is gated by reset so every output reads zero while rst_in is held.
  assign req_ready_out      = (r_state == IDLE && !rst_in) ? w_grant : '0;
  assign resp_valid_out     = (r_state == RESPOND) ? (NUM_REQ'(1) << r_owner) : '0;
  assign resp_quotient_out  = r_resp_q;
  assign resp_remainder_out = r_resp_r;
  assign div_dividend_out   = r_div_dividend;
  assign div_divisor_out    = r_div_divisor;
  assign div_valid_out      = (r_state == ISSUE);
  assign busy_out           = (r_state != IDLE);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state        <= IDLE;
      r_last_grant   <= IDX_W'(NUM_REQ - 1);
      r_owner        <= '0;
      r_cnt          <= '0;
      r_div_dividend <= '0;
      r_div_divisor  <= '0;
      r_resp_q       <= '0;
      r_resp_r       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner        <= w_idx;
            r_last_grant   <= w_idx;
            r_div_dividend <= w_sel_dividend;
            r_div_divisor  <= w_sel_divisor;
            if (w_zero_div) begin
              r_resp_q <= '1;
              r_resp_r <= w_sel_dividend;
              r_state  <= RESPOND;
            end else begin
              r_state  <= ISSUE;
            end
          end
        end
        ISSUE: begin
          r_cnt   <= CNT_LOAD;
          r_state <= WAIT;
        end
        WAIT: begin
          // Counter reaches zero in the cycle the divider result is valid.
          if (r_cnt == '0) begin
            r_resp_q <= div_quotient_in;
            r_resp_r <= div_remainder_in;
            r_state  <= RESPOND;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESPOND: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
